// File: rtl/time_of_day_counter.sv
// Time-of-day clock: prescaled 1 s tick, sec/min/hr24 carry chain, validated load,
// minute-resolution alarm and 24h/12h display formatting.
module time_of_day_counter #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode24,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [4:0] load_hour,
  input  logic       alarm_en,
  input  logic [5:0] alarm_min,
  input  logic [4:0] alarm_hour,
  output logic [5:0] SECOND,
  output logic [5:0] MINUTE,
  output logic [4:0] HOUR,
  output logic       pm,
  output logic       tick,
  output logic       complete,
  output logic       alarm,
  output logic       load_ack,
  output logic       load_err
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [5:0]    sec, min;
  logic [4:0]    hr24;

  logic          cnt_last;
  logic          load_ok;
  logic [5:0]    sec_n, min_n;
  logic [4:0]    hr_n;
  logic          wrap;
  logic          alarm_hit;

  // Whole carry chain resolved combinationally so every field updates on one edge.
  always_comb begin
    cnt_last = (cnt == CNT_LAST);
    load_ok  = (load_sec <= 6'd59) && (load_min <= 6'd59) && (load_hour <= 5'd23);
    sec_n    = sec;
    min_n    = min;
    hr_n     = hr24;
    wrap     = 1'b0;
    if (sec == 6'd59) begin
      sec_n = '0;
      if (min == 6'd59) begin
        min_n = '0;
        if (hr24 == 5'd23) begin
          hr_n = '0;
          wrap = 1'b1;
        end else begin
          hr_n = hr24 + 5'd1;
        end
      end else begin
        min_n = min + 6'd1;
      end
    end else begin
      sec_n = sec + 6'd1;
    end
    // Out-of-range alarm settings can never equal a legal next time.
    alarm_hit = alarm_en && (sec_n == 6'd0) && (min_n == alarm_min) && (hr_n == alarm_hour);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      sec      <= '0;
      min      <= '0;
      hr24     <= '0;
      tick     <= 1'b0;
      complete <= 1'b0;
      alarm    <= 1'b0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      complete <= 1'b0;
      alarm    <= 1'b0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          sec      <= load_sec;
          min      <= load_min;
          hr24     <= load_hour;
          cnt      <= '0;
          load_ack <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end else if (enable) begin
        if (cnt_last) begin
          cnt      <= '0;
          sec      <= sec_n;
          min      <= min_n;
          hr24     <= hr_n;
          tick     <= 1'b1;
          complete <= wrap;
          alarm    <= alarm_hit;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    SECOND = sec;
    MINUTE = min;
    pm     = (hr24 >= 5'd12);
    if (mode24)
      HOUR = hr24;
    else if ((hr24 == 5'd0) || (hr24 == 5'd12))
      HOUR = 5'd12;
    else if (hr24 > 5'd12)
      HOUR = hr24 - 5'd12;
    else
      HOUR = hr24;
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: TICK_DIV=1 and TICK_DIV=4 instances on shared inputs,
// directed scenarios plus random stimulus against a seconds-of-day reference model.
module tb_time_of_day_counter;

  logic       clock = 1'b0;
  logic       reset, enable, mode24, load, alarm_en;
  logic [5:0] load_sec, load_min, alarm_min;
  logic [4:0] load_hour, alarm_hour;

  logic [5:0] sec_o [2];
  logic [5:0] min_o [2];
  logic [4:0] hour_o[2];
  logic       pm_o[2], tick_o[2], comp_o[2], alarm_o[2], ack_o[2], err_o[2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: time as seconds since midnight, plus prescaler phase per instance.
  int tod[2];
  int ph[2];
  bit e_tick[2], e_comp[2], e_alarm[2];
  bit e_ack, e_err;

  always #5 clock = ~clock;

  time_of_day_counter #(.TICK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .mode24(mode24), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .alarm_en(alarm_en), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .SECOND(sec_o[0]), .MINUTE(min_o[0]), .HOUR(hour_o[0]), .pm(pm_o[0]),
    .tick(tick_o[0]), .complete(comp_o[0]), .alarm(alarm_o[0]),
    .load_ack(ack_o[0]), .load_err(err_o[0])
  );

  time_of_day_counter #(.TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .mode24(mode24), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .alarm_en(alarm_en), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .SECOND(sec_o[1]), .MINUTE(min_o[1]), .HOUR(hour_o[1]), .pm(pm_o[1]),
    .tick(tick_o[1]), .complete(comp_o[1]), .alarm(alarm_o[1]),
    .load_ack(ack_o[1]), .load_err(err_o[1])
  );

  function automatic int exp_hour(int t, logic m24);
    int h = t / 3600;
    if (m24) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  // Advance the model with the inputs present before the edge, then step one clock.
  task automatic cyc();
    int lt  = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
    bit ok  = (load_sec < 60) && (load_min < 60) && (load_hour < 24);
    int at  = int'(alarm_hour) * 3600 + int'(alarm_min) * 60;
    bit aok = (alarm_min < 60) && (alarm_hour < 24);
    e_ack = 1'b0;
    e_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int d = (i == 0) ? 1 : 4;
      e_tick[i]  = 1'b0;
      e_comp[i]  = 1'b0;
      e_alarm[i] = 1'b0;
      if (reset) begin
        tod[i] = 0;
        ph[i]  = 0;
      end else if (load) begin
        if (ok) begin
          tod[i] = lt;
          ph[i]  = 0;
        end
      end else if (enable) begin
        if (ph[i] == d - 1) begin
          ph[i]      = 0;
          tod[i]     = (tod[i] + 1) % 86400;
          e_tick[i]  = 1'b1;
          e_comp[i]  = (tod[i] == 0);
          e_alarm[i] = alarm_en && aok && (tod[i] == at);
        end else begin
          ph[i] = ph[i] + 1;
        end
      end
    end
    if (!reset && load) begin
      e_ack = ok;
      e_err = !ok;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_load(input int h, input int m, input int s);
    load      = 1'b1;
    load_hour = 5'(h);
    load_min  = 6'(m);
    load_sec  = 6'(s);
  endtask

  task automatic test_reset();
    reset = 1'b1; mode24 = 1'b0; enable = 1'b0; load = 1'b0;
    cyc();
    n_cmp++;
    if ({hour_o[0], min_o[0], sec_o[0], pm_o[0]} !== {5'd12, 6'd0, 6'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_time12: got %0d:%0d:%0d pm=%b want 12:0:0 pm=0",
               hour_o[0], min_o[0], sec_o[0], pm_o[0]);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({tick_o[i], comp_o[i], alarm_o[i], ack_o[i], err_o[i]} !== 5'b00000) begin
        n_bad++;
        $display("FAIL reset_pulses[%0d]: got %b want 00000", i,
                 {tick_o[i], comp_o[i], alarm_o[i], ack_o[i], err_o[i]});
      end
    end
    mode24 = 1'b1;
    #1;
    n_cmp++;
    if ({hour_o[0], hour_o[1]} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_hour24: got %0d/%0d want 0/0", hour_o[0], hour_o[1]);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    logic [16:0] want_t[3];
    logic [4:0]  want_p[3];
    want_t = '{{5'd23, 6'd59, 6'd58}, {5'd23, 6'd59, 6'd59}, {5'd0, 6'd0, 6'd0}};
    want_p = '{5'b00010, 5'b10000, 5'b11000};
    mode24 = 1'b1; enable = 1'b0;
    set_load(23, 59, 58);
    for (int k = 0; k < 3; k++) begin
      cyc();
      load = 1'b0; enable = 1'b1;
      n_cmp++;
      if ({hour_o[0], min_o[0], sec_o[0], tick_o[0], comp_o[0], alarm_o[0], ack_o[0], err_o[0]}
          !== {want_t[k], want_p[k]}) begin
        n_bad++;
        $display("FAIL wrap_step%0d: got %0d:%0d:%0d pulses=%b want %h pulses=%b", k,
                 hour_o[0], min_o[0], sec_o[0],
                 {tick_o[0], comp_o[0], alarm_o[0], ack_o[0], err_o[0]}, want_t[k], want_p[k]);
      end
    end
    enable = 1'b0;
    cyc();
    n_cmp++;
    if ({tick_o[0], comp_o[0]} !== 2'b00) begin
      n_bad++;
      $display("FAIL wrap_single_cycle: got tick=%b complete=%b want 0 0", tick_o[0], comp_o[0]);
    end
  endtask

  task automatic test_12h();
    int hrs[5]  = '{13, 12, 0, 11, 23};
    int disp[5] = '{1, 12, 12, 11, 11};
    bit pms[5]  = '{1, 1, 0, 0, 1};
    mode24 = 1'b0; enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_load(hrs[k], 5, 0);
      cyc();
      n_cmp++;
      if ({hour_o[0], pm_o[0]} !== {5'(disp[k]), pms[k]}) begin
        n_bad++;
        $display("FAIL hour12_%0d: got HOUR=%0d pm=%b want HOUR=%0d pm=%b", hrs[k],
                 hour_o[0], pm_o[0], disp[k], pms[k]);
      end
    end
    load = 1'b0;
    mode24 = 1'b1;
    #1;
    n_cmp++;
    if (hour_o[0] !== 5'd23) begin
      n_bad++;
      $display("FAIL mode_display_only: got HOUR=%0d want 23", hour_o[0]);
    end
  endtask

  task automatic test_load();
    int bad[3][3] = '{'{10, 60, 0}, '{24, 0, 0}, '{10, 20, 60}};
    mode24 = 1'b1; enable = 1'b0;
    set_load(10, 20, 30);
    cyc();
    for (int k = 0; k < 3; k++) begin
      set_load(bad[k][0], bad[k][1], bad[k][2]);
      cyc();
      n_cmp++;
      if ({hour_o[0], min_o[0], sec_o[0], ack_o[0], err_o[0]} !== {5'd10, 6'd20, 6'd30, 2'b01}) begin
        n_bad++;
        $display("FAIL invalid_load%0d: got %0d:%0d:%0d ack=%b err=%b want 10:20:30 ack=0 err=1",
                 k, hour_o[0], min_o[0], sec_o[0], ack_o[0], err_o[0]);
      end
    end
    enable = 1'b1;
    set_load(5, 6, 7);
    cyc();
    n_cmp++;
    if ({hour_o[0], min_o[0], sec_o[0], tick_o[0], ack_o[0]} !== {5'd5, 6'd6, 6'd7, 2'b01}) begin
      n_bad++;
      $display("FAIL load_beats_tick: got %0d:%0d:%0d tick=%b ack=%b want 5:6:7 tick=0 ack=1",
               hour_o[0], min_o[0], sec_o[0], tick_o[0], ack_o[0]);
    end
    set_load(2, 3, 4);
    cyc();
    n_cmp++;
    if ({hour_o[0], min_o[0], sec_o[0], ack_o[0]} !== {5'd2, 6'd3, 6'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL back_to_back_load: got %0d:%0d:%0d ack=%b want 2:3:4 ack=1",
               hour_o[0], min_o[0], sec_o[0], ack_o[0]);
    end
    load = 1'b0;
    cyc();
    n_cmp++;
    if ({hour_o[0], min_o[0], sec_o[0], tick_o[0], ack_o[0]} !== {5'd2, 6'd3, 6'd5, 2'b10}) begin
      n_bad++;
      $display("FAIL tick_after_load: got %0d:%0d:%0d tick=%b ack=%b want 2:3:5 tick=1 ack=0",
               hour_o[0], min_o[0], sec_o[0], tick_o[0], ack_o[0]);
    end
    enable = 1'b0;
  endtask

  task automatic test_div4();
    int gap = 99;
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    cyc();
    reset = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      n_cmp++;
      if (tick_o[1] !== (k % 4 == 0)) begin
        n_bad++;
        $display("FAIL div4_tick_c%0d: got %b want %b", k, tick_o[1], (k % 4 == 0));
      end
    end
    for (int c = 1; c <= 20; c++) begin
      enable = !(c >= 3 && c <= 5);
      cyc();
      if (tick_o[1]) begin
        gap = c;
        break;
      end
    end
    n_cmp++;
    if (gap != 7) begin
      n_bad++;
      $display("FAIL div4_stretch: got interval %0d want 7", gap);
    end
    n_cmp++;
    if (sec_o[1] !== 6'd4) begin
      n_bad++;
      $display("FAIL div4_seconds: got %0d want 4", sec_o[1]);
    end
    enable = 1'b0;
  endtask

  task automatic test_alarm();
    int ld[5][3] = '{'{7, 29, 59}, '{7, 29, 59}, '{7, 30, 0}, '{7, 59, 59}, '{23, 59, 59}};
    bit en[5]    = '{1, 0, 1, 1, 1};
    int am[5]    = '{30, 30, 30, 60, 0};
    int ah[5]    = '{7, 7, 7, 7, 0};
    bit dotk[5]  = '{1, 1, 0, 1, 1};
    logic [4:0] want[5] = '{5'b10100, 5'b10000, 5'b00010, 5'b10000, 5'b11100};
    mode24 = 1'b1; enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      alarm_en   = en[k];
      alarm_min  = 6'(am[k]);
      alarm_hour = 5'(ah[k]);
      set_load(ld[k][0], ld[k][1], ld[k][2]);
      cyc();
      load = 1'b0;
      if (dotk[k]) begin
        enable = 1'b1;
        cyc();
        enable = 1'b0;
      end
      n_cmp++;
      if ({tick_o[0], comp_o[0], alarm_o[0], ack_o[0], err_o[0]} !== want[k]) begin
        n_bad++;
        $display("FAIL alarm_case%0d: got pulses=%b want %b", k,
                 {tick_o[0], comp_o[0], alarm_o[0], ack_o[0], err_o[0]}, want[k]);
      end
    end
    cyc();
    n_cmp++;
    if (alarm_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL alarm_one_cycle: got %b want 0", alarm_o[0]);
    end
  endtask

  task automatic test_random();
    logic [22:0] got, want;
    reset = 1'b1; load = 1'b0;
    cyc();
    reset = 1'b0;
    alarm_min = 6'd30;
    for (int n = 0; n < 800; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      mode24   = $urandom_range(0, 1);
      alarm_en = $urandom_range(0, 1);
      load     = ($urandom_range(0, 11) == 0);
      if (load) begin
        if ($urandom_range(0, 3) == 0) begin
          set_load($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        end else begin
          set_load($urandom_range(0, 23), ($urandom_range(0, 1) != 0) ? 29 : 59,
                   $urandom_range(55, 59));
          alarm_hour = load_hour;
        end
      end
      cyc();
      for (int i = 0; i < 2; i++) begin
        got  = {hour_o[i], min_o[i], sec_o[i], pm_o[i],
                tick_o[i], comp_o[i], alarm_o[i], ack_o[i], err_o[i]};
        want = {5'(exp_hour(tod[i], mode24)), 6'((tod[i] / 60) % 60), 6'(tod[i] % 60),
                (tod[i] >= 43200), e_tick[i], e_comp[i], e_alarm[i], e_ack, e_err};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL random[%0d] cycle %0d: got %h want %h", i, n, got, want);
        end
      end
    end
    load = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode24 = 1'b0; load = 1'b0; alarm_en = 1'b0;
    load_sec = '0; load_min = '0; load_hour = '0; alarm_min = '0; alarm_hour = '0;
    test_reset();
    test_wrap();
    test_12h();
    test_load();
    test_div4();
    test_alarm();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Parametrised successor to the team's seconds/minutes/hours clock chain, implemented as a single block. It generates a 1-second tick from the system clock through a prescaler and keeps time-of-day in an internal 0–23 hour format. The hour display is selectable between 24-hour and 12-hour with an AM/PM flag. It also supports a validated time-set load with acknowledge or error, and a minute-resolution alarm.

## Interface
- TICK_DIV, default 1: clock cycles per second tick; must be ≥1; prescaler width is clog2(TICK_DIV), minimum 1 bit.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset, sampled on the rising edge of clock.
- enable  in  1  count enable; low freezes the prescaler and time.
- mode24  in  1  1: HOUR shows 0–23; 0: HOUR shows 1–12 with pm.
- load  in  1  single-cycle time-set request.
- load_sec / load_min  in  6 / 6  requested seconds and minutes.
- load_hour  in  5  requested hour, always in 24-hour format.
- alarm_en  in  1  alarm compare enable.
- alarm_min / alarm_hour  in  6 / 5  alarm time, 24-hour format; seconds fixed at 00.
- SECOND / MINUTE  out  6 / 6  current seconds and minutes.
- HOUR  out  5  hour formatted per mode24.
- pm  out  1  1 when internal hour ≥12; valid in both modes.
- tick  out  1  one-cycle pulse each time the time advances.
- complete  out  1  one-cycle pulse on day wrap 23:59:59→00:00:00.
- alarm  out  1  one-cycle pulse on reaching the alarm time.
- load_ack / load_err  out  1 / 1  one-cycle pulses acknowledging or rejecting a load.

## Operation
- Internal state: prescaler cnt, sec (0–59), min (0–59), hr24 (0–23).
- Reset: cnt=0, sec=0, min=0, hr24=0.
  - Pulses tick, complete, alarm, load_ack and load_err are all 0.
  - SECOND=0, MINUTE=0, pm=0.
  - HOUR=0 if mode24=1, HOUR=12 if mode24=0.
- Reset has priority over every other input.
- Advance condition: adv = enable && cnt==TICK_DIV-1 && !load.
  - With enable=1 and no adv: cnt increments.
  - On adv: cnt←0 and sec increments.
- Carry chain:
  - sec 59→0 carries into min.
  - min 59→0 carries into hr24.
  - hr24 23→0 wraps the day.
  - All carries resolve in the same edge; there is no ripple delay between fields.
- enable=0: cnt and time hold.
- Load (load=1, not in reset):
  - Valid if load_sec≤59, load_min≤59 and load_hour≤23.
  - Valid load: sec/min/hr24 take the load values, cnt←0, load_ack=1 next cycle.
  - Invalid load: time and cnt unchanged, load_err=1 next cycle.
  - Load wins over a coincident advance; that tick is discarded and tick stays 0.
  - Load is accepted regardless of enable.
- Display formatting (combinational from registers):
  - mode24=1: HOUR=hr24.
  - mode24=0: HOUR=12 when hr24 is 0 or 12; HOUR=hr24-12 when hr24>12; otherwise HOUR=hr24.
  - pm = hr24≥12.
  - Changing mode24 affects the display only, never the stored time.
- Alarm fires only on an advance: when alarm_en=1 and the new time equals alarm_hour:alarm_min:00.
  - A load landing on the alarm time does not fire the alarm.
  - An out-of-range alarm setting never fires.

## Timing
- All pulse outputs are registered and high for exactly one cycle.
- Pulses are asserted in the cycle after the advancing or loading edge, concurrent with the updated time value.
- Latency from the load request cycle to visible new time and load_ack: 1 cycle.
- With TICK_DIV=N and enable held high, ticks occur every N cycles; the first tick comes N cycles after reset deasserts.
- TICK_DIV=1: the time advances on every enabled cycle.
- complete and tick pulse together on the day wrap; alarm may coincide with both (alarm at 00:00).
- Reset asserted mid-count clears everything at the next edge; any pending load or advance in that cycle is dropped.
- Back-to-back load requests are each processed, one per cycle.

## Test plan
- Reset with mode24=0 → SECOND=0, MINUTE=0, HOUR=12, pm=0, all pulses 0; set mode24=1 → HOUR=0.
- TICK_DIV=1: load 23:59:58 → load_ack; two enabled cycles → 23:59:59, then 00:00:00 with complete=1 and tick=1 in that cycle only.
- mode24=0: load hr 13 → HOUR=1, pm=1; load hr 12 → HOUR=12, pm=1; load hr 0 → HOUR=12, pm=0.
- Invalid load of 10:60:00 → load_err=1, time unchanged, no load_ack. Load asserted on a tick cycle → loaded value appears and the tick is suppressed.
- TICK_DIV=4: enable high → tick every 4 cycles. Drop enable for 3 cycles mid-count → the count resumes at the held phase, stretching that tick interval by 3 cycles.
- Alarm at 07:30, alarm_en=1: load 07:29:59, then one tick → alarm=1. alarm_en=0 → no pulse. Load 07:30:00 directly → no pulse.
